// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared types and constants for the program-run controller
package run_ctrl_pkg;

  // Controller states; busy covers ARMED through STEP_EXEC
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    RUN       = 3'd2,
    STEP_WAIT = 3'd3,
    STEP_EXEC = 3'd4,
    DONE      = 3'd5,
    FAULT     = 3'd6
  } run_state_e;

  // Instruction the core top level feeds the decoder while run is low
  localparam logic [8:0] NOP_INSTR = 9'h1FF;

  // Program-select width; a single program still needs a 1-bit select port
  function automatic int sel_width(input int num_prog);
    return (num_prog <= 1) ? 1 : $clog2(num_prog);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  // Value the counter takes if enabled this cycle; exposed so callers can
  // compare against a limit in the same cycle the increment happens
  assign count_next = (count == MAX) ? count : count + ONE;

  // Clear wins over enable so a restart never carries a stale count
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - program-run controller: arm/preload, run, single-step, watchdog, done
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int                       PC_W      = 10,
  parameter int                       CNT_W     = 16,
  parameter int                       NUM_PROG  = 4,
  parameter logic [NUM_PROG*PC_W-1:0] PROG_BASE = {10'd768, 10'd512, 10'd256, 10'd0},
  parameter int                       TIMEOUT   = 0,
  localparam int                      SEL_W     = sel_width(NUM_PROG)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [SEL_W-1:0] prog_sel,
  input  logic             step_mode,
  input  logic             step,
  input  logic             core_done,
  output logic             run,
  output logic             pc_load,
  output logic [PC_W-1:0]  pc_load_addr,
  output logic             pc_hold,
  output logic             done,
  output logic             fault,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_count
);

  // Table is padded to a power of two so any select value indexes a real entry
  localparam int                TAB_N      = 1 << SEL_W;
  localparam longint            CNT_MAX    = (longint'(1) << CNT_W) - 1;
  // A limit the saturating counter can never reach is treated as disabled
  localparam bit                WD_EN      = (TIMEOUT > 0) && (longint'(TIMEOUT) <= CNT_MAX);
  localparam logic [CNT_W-1:0]  WD_LIMIT   = WD_EN ? CNT_W'(TIMEOUT) : '0;
  localparam logic [SEL_W:0]    NUM_PROG_V = (SEL_W + 1)'(NUM_PROG);

  if (TIMEOUT != 0 && !WD_EN) begin : g_wd_unreachable
    $warning("run_ctrl: TIMEOUT exceeds cycle counter range, watchdog disabled");
  end

  run_state_e       state;
  logic [SEL_W-1:0] sel_q;
  logic             sel_ok;
  logic             accept;
  logic             wd_hit;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [PC_W-1:0]  base_tab [TAB_N];

  for (genvar i = 0; i < TAB_N; i++) begin : g_tab
    if (i < NUM_PROG) begin : g_used
      assign base_tab[i] = PROG_BASE[i*PC_W +: PC_W];
    end else begin : g_pad
      assign base_tab[i] = '0;
    end
  end

  // Out-of-range program numbers fall back to program 0
  assign sel_ok = ({1'b0, prog_sel} < NUM_PROG_V);

  // A new run is only accepted from a resting state; start while busy is ignored
  assign accept = start && (state == IDLE || state == DONE || state == FAULT);

  // Watchdog compares the count this cycle will produce, so the fault lands
  // right after the TIMEOUT-th executed cycle
  assign wd_hit = WD_EN && (count_next == WD_LIMIT);

  // Control FSM; core_done beats the watchdog, which beats a step-mode pause
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel_q <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAULT: begin
          if (start) begin
            state <= ARMED;
            sel_q <= sel_ok ? prog_sel : '0;
          end
        end
        ARMED: begin
          if (!start) begin
            state <= step_mode ? STEP_WAIT : RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            state <= DONE;
          end else if (wd_hit) begin
            state <= FAULT;
          end else if (step_mode) begin
            state <= STEP_WAIT;
          end
        end
        STEP_WAIT: begin
          if (!step_mode) begin
            state <= RUN;
          end else if (step) begin
            state <= STEP_EXEC;
          end
        end
        STEP_EXEC: begin
          if (core_done) begin
            state <= DONE;
          end else if (wd_hit) begin
            state <= FAULT;
          end else begin
            state <= STEP_WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear     (accept),
    .en        (run),
    .count     (count),
    .count_next(count_next)
  );

  assign run          = (state == RUN) || (state == STEP_EXEC);
  assign pc_hold      = ~run;
  assign pc_load      = (state == ARMED);
  assign pc_load_addr = pc_load ? base_tab[sel_q] : '0;
  assign done         = (state == DONE) || (state == FAULT);
  assign fault        = (state == FAULT);
  assign busy         = (state == ARMED) || (state == RUN) ||
                        (state == STEP_WAIT) || (state == STEP_EXEC);
  assign cycle_count  = count;

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Parametrised program-run controller for the accumulator core. It replaces the ad-hoc start-delay, done gating and cycle counter at core top level. Adds:
- program selection: PC preload from a base-address table
- single-step debug mode
- saturating executed-cycle counter
- watchdog timeout with fault flag

It sits between the external start/done handshake and the PC / control decoder. `run` gates the decoder: when `run`=0 the top level feeds the all-ones NOP instruction.

Parameters:
PC_W, 10, PC / instruction address width
CNT_W, 16, cycle counter width
NUM_PROG, 4, number of selectable programs (>=1)
PROG_BASE, {10'd768,10'd512,10'd256,10'd0}, packed NUM_PROG x PC_W base-address table; entry i = program i
TIMEOUT, 0, max run cycles before fault; 0 = watchdog disabled

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  level request; run begins after it falls
prog_sel  in  SEL_W=max(1,$clog2(NUM_PROG))  program index, sampled on start rise
step_mode  in  1  1 = pause after current cycle; execute only on step
step  in  1  single-cycle pulse; executes one instruction in step mode
core_done  in  1  decoder done (halt instruction decoded)
run  out  1  instruction valid to decoder / core executing this cycle
pc_load  out  1  PC loads pc_load_addr this cycle
pc_load_addr  out  PC_W  selected program base
pc_hold  out  1  PC must not advance (= ~run)
done  out  1  sticky completion flag
fault  out  1  sticky watchdog fault
busy  out  1  state in ARMED/RUN/STEP_WAIT/STEP_EXEC
cycle_count  out  CNT_W  cycles with run=1 in current/last program

Behaviour:
- States: IDLE, ARMED, RUN, STEP_WAIT, STEP_EXEC, DONE, FAULT. Registered state; outputs decoded from state, except run as below.
- Reset (any state, mid-run included): next state IDLE. Outputs after reset: run=0, pc_load=0, pc_load_addr=0, pc_hold=1, done=0, fault=0, busy=0, cycle_count=0.
- IDLE/DONE/FAULT, start=1: go to ARMED.
  - Latch prog_sel. If prog_sel>=NUM_PROG, use index 0.
  - Clear done, fault, cycle_count.
- ARMED:
  - pc_load=1, pc_load_addr=PROG_BASE[latched sel], run=0.
  - Stay while start=1. On start=0, go to RUN (step_mode=0) or STEP_WAIT (step_mode=1).
  - First instruction is therefore issued 1 cycle after start falls.
- RUN: run=1; cycle_count+=1 per cycle, saturating at all-ones (no wrap). Priority order in the same cycle:
  1. core_done -> DONE
  2. watchdog: TIMEOUT!=0 and post-increment count==TIMEOUT -> FAULT
  3. step_mode=1 -> STEP_WAIT
  4. otherwise stay in RUN
- STEP_WAIT: run=0, PC held.
  - step_mode=0 -> RUN (step ignored in that cycle).
  - Else step=1 -> STEP_EXEC.
- STEP_EXEC: run=1 for exactly one cycle; counts one cycle.
  - core_done -> DONE; watchdog -> FAULT; else -> STEP_WAIT.
  - A step held high re-steps every 2 cycles. Edge detection is the caller's responsibility.
- DONE: done=1, run=0, cycle_count frozen.
- FAULT: fault=1, done=1, run=0, cycle_count frozen.
- start while busy is ignored; there is no abort except reset.
- core_done when run=0 is ignored.
- Watchdog is off when TIMEOUT=0 or TIMEOUT > 2^CNT_W-1 (saturation makes it unreachable; elaboration warning).
- Latency: start fall -> run=1 in 1 cycle; core_done (run=1) -> done=1 next cycle.

Decomposition:
- run_ctrl_pkg:
  - state enum run_state_e (IDLE..FAULT)
  - localparam function for SEL_W
  - NOP_INSTR = 9'h1FF constant, used by the top-level gating
- One sub-module, sat_counter #(W): synchronous clear, enable, saturate-at-max. Used for cycle_count.

Test Plan:
- Reset, then start high 3 cycles with prog_sel=2:
  - pc_load=1 with pc_load_addr=512 during ARMED.
  - run=1 exactly 1 cycle after start falls.
  - core_done asserted on the 5th run cycle -> done=1 next cycle, cycle_count=5, busy=0.
- step_mode=1 at start, then 3 step pulses spaced 4 cycles:
  - run=1 in exactly 3 isolated cycles, cycle_count=3.
  - Deassert step_mode -> RUN resumes the next cycle.
- TIMEOUT=10, core_done never asserted:
  - fault=1 and done=1 after the 10th run cycle, cycle_count=10.
- Same-cycle conflicts:
  - core_done together with the 10th cycle -> done=1, fault=0.
  - Separately: step and step_mode falling in the same cycle -> RUN, no extra STEP_EXEC.
- Reset asserted mid-RUN at count 7:
  - Next cycle IDLE, all outputs at reset values.
  - New start with prog_sel=5 (out of range) -> pc_load_addr=0.
- CNT_W=4, TIMEOUT=0, 20 run cycles:
  - cycle_count saturates at 15.
  - start pulse during RUN is ignored; a start after DONE clears done and the count.
